bcd_counter_display: RTL and testbench

Parametrised multi-digit decimal counter with a time-multiplexed seven-segment display driver. It generalises the single-digit counter-plus-decoder pair to DIGITS BCD digits. It adds a tick prescaler, up/down counting, a synchronous parallel load and a wrap pulse, and scans one shared segment bus across per-digit anode enables. It sits at the top of a lab design, between the board clock/buttons and the display pins.

---
 rtl/bcd_counter_display.sv | 157 +++++++++++++++
 tb/tb_bcd_counter_display.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with prescaled tick, parallel load, wrap
// pulse and a time-multiplexed seven-segment display driver.
module bcd_counter_display #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 50000000,
    parameter int REFRESH    = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic                carry,
    output logic [6:0]          segments,
    output logic [DIGITS-1:0]   anodes
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(DIGITS - 1);

    logic [PW-1:0]         r_prescale;
    logic [4*DIGITS-1:0]   r_count;
    logic                  r_carry;
    logic [RW-1:0]         r_refresh;
    logic [SW-1:0]         r_scan;

    logic                  w_tick;
    logic [4*DIGITS-1:0]   w_count_step;
    logic                  w_wrap;
    logic [4*DIGITS-1:0]   w_load_clean;
    logic [3:0]            w_digit_sel;
    logic [DIGITS-1:0]     w_anodes_hi;
    logic [6:0]            w_seg_hi;

    assign w_tick = en && (r_prescale == PRE_LAST);

    // Ripple the +1/-1 across digits; w_wrap stays set only while every
    // digit visited so far rolled over, so it ends as the whole-count wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
        w_count_step = r_count;
        w_wrap       = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_wrap) begin
                if (up) begin
                    if (r_count[4*i +: 4] >= 4'd9) begin
                        w_count_step[4*i +: 4] = 4'd0;
                    end else begin
                        w_count_step[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                        w_wrap                 = 1'b0;
                    end
                end else begin
                    if (r_count[4*i +: 4] == 4'd0) begin
                        w_count_step[4*i +: 4] = 4'd9;
                    end else begin
                        w_count_step[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                        w_wrap                 = 1'b0;
                    end
                end
            end
        end
    end

    // Replace any non-decimal nibble of the load value with 0.
    always_comb begin
        w_load_clean = load_value;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_value[4*i +: 4] > 4'd9) begin
                w_load_clean[4*i +: 4] = 4'd0;
            end
        end
    end

    // Prescaler: advances on enabled cycles, restarts on a tick or a load.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_prescale <= '0;
        end else if (load || w_tick) begin
            r_prescale <= '0;
        end else if (en) begin
            r_prescale <= r_prescale + PW'(1);
        end
    end

    // Count register and registered wrap pulse; load wins over a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clean;
            r_carry <= 1'b0;
        end else if (w_tick) begin
            r_count <= w_count_step;
            r_carry <= w_wrap;
        end else begin
            r_carry <= 1'b0;
        end
    end

    // Display scan: refresh counter free-runs and steps the digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh <= '0;
            r_scan    <= '0;
        end else if (r_refresh == REF_LAST) begin
            r_refresh <= '0;
            r_scan    <= (r_scan == SCAN_LAST) ? '0 : r_scan + SW'(1);
        end else begin
            r_refresh <= r_refresh + RW'(1);
        end
    end

    // Select the scanned digit and its one-hot anode.
    always_comb begin
        w_digit_sel = 4'd0;
        w_anodes_hi = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scan == SW'(i)) begin
                w_digit_sel    = r_count[4*i +: 4];
                w_anodes_hi[i] = 1'b1;
            end
        end
    end

    // Seven-segment decode, active-high gfedcba.
    always_comb begin
        case (w_digit_sel)
            4'd0:    w_seg_hi = 7'b0111111;
            4'd1:    w_seg_hi = 7'b0000110;
            4'd2:    w_seg_hi = 7'b1011011;
            4'd3:    w_seg_hi = 7'b1001111;
            4'd4:    w_seg_hi = 7'b1100110;
            4'd5:    w_seg_hi = 7'b1101101;
            4'd6:    w_seg_hi = 7'b1111101;
            4'd7:    w_seg_hi = 7'b0000111;
            4'd8:    w_seg_hi = 7'b1111111;
            4'd9:    w_seg_hi = 7'b1101111;
            default: w_seg_hi = 7'b0000000;
        endcase
    end

    assign count_bcd = r_count;
    assign carry     = r_carry;
    assign segments  = (ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
    assign anodes    = (ACTIVE_LOW != 0) ? ~w_anodes_hi : w_anodes_hi;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Bench for bcd_counter_display: directed scenarios followed by random
// stimulus, all compared against an arithmetic model of the counter.
module tb_bcd_counter_display;

    localparam int DIGITS     = 2;
    localparam int PRESCALE   = 4;
    localparam int REFRESH    = 2;
    localparam int ACTIVE_LOW = 1;
    localparam int LW         = 4 * DIGITS;
    localparam int MOD        = 10 ** DIGITS;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          up;
    logic          load;
    logic [LW-1:0] load_value;
    logic [LW-1:0] count_bcd;
    logic          carry;
    logic [6:0]    segments;
    logic [DIGITS-1:0] anodes;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: count as a plain integer, counters as integers.
    int   m_count = 0;
    int   m_pre   = 0;
    int   m_ref   = 0;
    int   m_scan  = 0;
    logic m_carry = 1'b0;
    bit   carry_seen;

    always #5 clk = ~clk;

    bcd_counter_display #(
        .DIGITS    (DIGITS),
        .PRESCALE  (PRESCALE),
        .REFRESH   (REFRESH),
        .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_value(load_value),
        .count_bcd (count_bcd),
        .carry     (carry),
        .segments  (segments),
        .anodes    (anodes)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clean_load(input logic [LW-1:0] v);
        int r = 0;
        int w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'(v[4*i +: 4]);
            if (d > 9) d = 0;
            r += d * w;
            w *= 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int digit_of(input int v, input int idx);
        for (int i = 0; i < idx; i++) v = v / 10;
        return v % 10;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    task automatic model_step();
        if (reset) begin
            m_count = 0;
            m_pre   = 0;
            m_ref   = 0;
            m_scan  = 0;
            m_carry = 1'b0;
        end else begin
            m_carry = 1'b0;
            if (load) begin
                m_count = clean_load(load_value);
                m_pre   = 0;
            end else if (en) begin
                if (m_pre == PRESCALE - 1) begin
                    m_pre = 0;
                    if (up) begin
                        m_carry = (m_count == MOD - 1);
                        m_count = (m_count + 1) % MOD;
                    end else begin
                        m_carry = (m_count == 0);
                        m_count = (m_count + MOD - 1) % MOD;
                    end
                end else begin
                    m_pre++;
                end
            end
            if (m_ref == REFRESH - 1) begin
                m_ref  = 0;
                m_scan = (m_scan + 1) % DIGITS;
            end else begin
                m_ref++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [DIGITS-1:0] a;
        logic [6:0]        s;
        a         = '0;
        a[m_scan] = 1'b1;
        s         = seg_of(digit_of(m_count, m_scan));
        if (ACTIVE_LOW != 0) begin
            a = ~a;
            s = ~s;
        end
        chk("model_count", 32'(count_bcd), to_bcd(m_count));
        chk("model_carry", 32'(carry), 32'(m_carry));
        chk("model_anodes", 32'(anodes), 32'(a));
        chk("model_segments", 32'(segments), 32'(s));
    endtask

    // One clock: update the model on the edge, sample the DUT 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        if (carry === 1'b1) carry_seen = 1'b1;
    endtask

    initial begin
        logic [LW-1:0] prev;
        int            last_change;
        int            guard;

        reset      = 1'b1;
        en         = 1'b0;
        up         = 1'b1;
        load       = 1'b0;
        load_value = '0;
        carry_seen = 1'b0;

        // Reset held: fixed reset values, scan frozen.
        repeat (3) cycle();
        chk("rst_count", 32'(count_bcd), 'h00);
        chk("rst_carry", 32'(carry), 0);
        chk("rst_anodes", 32'(anodes), 'b10);
        chk("rst_segments", 32'(segments), 'b1000000);
        en = 1'b1;
        repeat (4) begin
            cycle();
            chk("rst_hold_count", 32'(count_bcd), 'h00);
            chk("rst_hold_anodes", 32'(anodes), 'b10);
            chk("rst_hold_segments", 32'(segments), 'b1000000);
        end

        // Up count for 48 cycles: 12 ticks, spaced 4 cycles, no carry.
        reset       = 1'b0;
        en          = 1'b1;
        up          = 1'b1;
        carry_seen  = 1'b0;
        prev        = count_bcd;
        last_change = 0;
        for (int k = 1; k <= 48; k++) begin
            cycle();
            if (count_bcd !== prev) begin
                chk("tick_spacing", k - last_change, PRESCALE);
                last_change = k;
                prev        = count_bcd;
            end
        end
        chk("up_48_count", 32'(count_bcd), 'h12);
        chk("up_no_carry", 32'(carry_seen), 0);

        // Wrap upward from 99.
        load       = 1'b1;
        load_value = 8'h99;
        cycle();
        chk("load_99", 32'(count_bcd), 'h99);
        load = 1'b0;
        repeat (3) cycle();
        chk("wrap_up_wait", 32'(count_bcd), 'h99);
        cycle();
        chk("wrap_up_count", 32'(count_bcd), 'h00);
        chk("wrap_up_carry", 32'(carry), 1);
        cycle();
        chk("wrap_up_carry_drop", 32'(carry), 0);

        // Wrap downward from 00.
        load       = 1'b1;
        load_value = 8'h00;
        up         = 1'b0;
        cycle();
        load = 1'b0;
        repeat (3) cycle();
        chk("wrap_dn_wait", 32'(count_bcd), 'h00);
        chk("wrap_dn_no_carry", 32'(carry), 0);
        cycle();
        chk("wrap_dn_count", 32'(count_bcd), 'h99);
        chk("wrap_dn_carry", 32'(carry), 1);
        cycle();
        chk("wrap_dn_carry_drop", 32'(carry), 0);

        // Load on the edge a tick is due: tick discarded, nibble A cleaned.
        up    = 1'b1;
        guard = 0;
        while (m_pre != PRESCALE - 1 && guard < 16) begin
            cycle();
            guard++;
        end
        chk("tick_due_reached", m_pre, PRESCALE - 1);
        load       = 1'b1;
        load_value = 8'hA5;
        cycle();
        chk("load_a5_count", 32'(count_bcd), 'h05);
        chk("load_a5_carry", 32'(carry), 0);
        load = 1'b0;
        repeat (3) cycle();
        chk("load_no_early_tick", 32'(count_bcd), 'h05);
        cycle();
        chk("load_next_tick", 32'(count_bcd), 'h06);

        // Scan of 42 with counting frozen.
        load       = 1'b1;
        load_value = 8'h42;
        en         = 1'b0;
        cycle();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("scan_count", 32'(count_bcd), 'h42);
            chk("scan_anodes", 32'(anodes), (m_scan == 0) ? 'b10 : 'b01);
            chk("scan_segments", 32'(segments), (m_scan == 0) ? 'b0100100 : 'b0011001);
        end

        // Enable gating: prescaler holds mid-count while en is low.
        load       = 1'b1;
        load_value = 8'h00;
        en         = 1'b1;
        cycle();
        load = 1'b0;
        repeat (6) cycle();
        chk("hold_pre_count", 32'(count_bcd), 'h01);
        en = 1'b0;
        repeat (10) begin
            cycle();
            chk("hold_count", 32'(count_bcd), 'h01);
        end
        en = 1'b1;
        cycle();
        chk("resume_1", 32'(count_bcd), 'h01);
        cycle();
        chk("resume_2", 32'(count_bcd), 'h02);

        // Reset during the run, coincident with a load.
        reset      = 1'b1;
        load       = 1'b1;
        load_value = 8'h77;
        cycle();
        chk("midrun_rst_count", 32'(count_bcd), 'h00);
        chk("midrun_rst_anodes", 32'(anodes), 'b10);
        chk("midrun_rst_carry", 32'(carry), 0);
        reset = 1'b0;
        load  = 1'b0;

        // Random traffic against the model.
        repeat (800) begin
            reset = ($urandom_range(0, 149) == 0);
            load  = ($urandom_range(0, 14) == 0);
            en    = ($urandom_range(0, 3) != 0);
            up    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       load_value = 8'h99;
                1:       load_value = 8'h00;
                default: load_value = LW'($urandom);
            endcase
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
